lcd_char_controller: RTL and testbench

Character-LCD bus controller for an HD44780-compatible panel in 8-bit write-only mode. It sits directly downstream of the text-producing FSMs, such as the push-button display logic. It runs the panel power-up/initialisation sequence, then accepts one character per start/done handshake and drives the LCD pins with the required enable-pulse timing. It also tracks the cursor across a 2x16 display and inserts line-change address commands automatically.

---
 rtl/lcd_char_controller.sv | 195 +++++++++++++++++++
 tb/tb_lcd_char_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_char_controller.sv
// HD44780-compatible character-LCD controller, 8-bit write-only bus.
// Runs the power-up/init sequence, then writes one character per start/done handshake on a 2x16 panel.
module lcd_char_controller #(
  parameter int unsigned POWERUP_CYCLES    = 2000000,
  parameter int unsigned EN_HIGH_CYCLES    = 50,
  parameter int unsigned CMD_WAIT_CYCLES   = 5000,
  parameter int unsigned CLEAR_WAIT_CYCLES = 200000
) (
  input  logic       I_CLK,
  input  logic       I_RST_N,
  input  logic [7:0] I_DATA,
  input  logic       I_WRITE_START,
  output logic       O_INIT_DONE,
  output logic       O_WRITE_DONE,
  output logic [7:0] O_LCD_DB,
  output logic       O_LCD_RS,
  output logic       O_LCD_RW,
  output logic       O_LCD_E
);

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT,
    ST_IDLE,
    ST_CHAR,
    ST_WRAP,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_EN_HIGH,
    PH_SETTLE
  } phase_t;

  localparam logic [2:0] LAST_INIT_IDX = 3'd5;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_cmd = 8'h38;
      3'd3:             init_cmd = 8'h0C;
      3'd4:             init_cmd = 8'h01;
      default:          init_cmd = 8'h06;
    endcase
  endfunction

  state_t      state, state_n;
  phase_t      phase, phase_n;
  logic [31:0] cnt, cnt_n;
  logic [2:0]  init_idx, init_idx_n;
  logic [3:0]  col, col_n;
  logic        line, line_n;
  logic [7:0]  db_n;
  logic        rs_n, e_n, init_done_n, write_done_n;
  logic [31:0] settle_last;

  // Clear-display needs the long settle; the byte on the bus identifies the transaction.
  assign settle_last = (!O_LCD_RS && O_LCD_DB == 8'h01) ? 32'(CLEAR_WAIT_CYCLES - 1)
                                                        : 32'(CMD_WAIT_CYCLES - 1);

  assign O_LCD_RW = 1'b0;

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    state_n      = state;
    phase_n      = phase;
    cnt_n        = cnt;
    init_idx_n   = init_idx;
    col_n        = col;
    line_n       = line;
    db_n         = O_LCD_DB;
    rs_n         = O_LCD_RS;
    e_n          = 1'b0;
    init_done_n  = O_INIT_DONE;
    write_done_n = 1'b0;

    case (state)
      ST_POWERUP: begin
        if (cnt == 32'(POWERUP_CYCLES)) begin
          state_n    = ST_INIT;
          phase_n    = PH_SETUP;
          cnt_n      = '0;
          init_idx_n = '0;
          db_n       = init_cmd(3'd0);
          rs_n       = 1'b0;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end

      ST_IDLE: begin
        if (I_WRITE_START && O_INIT_DONE) begin
          state_n = ST_CHAR;
          phase_n = PH_SETUP;
          cnt_n   = '0;
          db_n    = I_DATA;
          rs_n    = 1'b1;
        end
      end

      ST_DONE: state_n = ST_IDLE;

      default: begin
        // Shared bus transaction engine for INIT, CHAR and WRAP.
        case (phase)
          PH_SETUP: begin
            phase_n = PH_EN_HIGH;
            cnt_n   = '0;
            e_n     = 1'b1;
          end

          PH_EN_HIGH: begin
            if (cnt == 32'(EN_HIGH_CYCLES - 1)) begin
              phase_n = PH_SETTLE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 32'd1;
              e_n   = 1'b1;
            end
          end

          default: begin
            if (cnt == settle_last) begin
              cnt_n = '0;
              case (state)
                ST_INIT: begin
                  if (init_idx == LAST_INIT_IDX) begin
                    state_n     = ST_IDLE;
                    init_done_n = 1'b1;
                  end else begin
                    init_idx_n = init_idx + 3'd1;
                    phase_n    = PH_SETUP;
                    db_n       = init_cmd(init_idx + 3'd1);
                  end
                end

                ST_CHAR: begin
                  if (col == 4'd15) begin
                    col_n   = '0;
                    line_n  = ~line;
                    state_n = ST_WRAP;
                    phase_n = PH_SETUP;
                    db_n    = line ? 8'h80 : 8'hC0;
                    rs_n    = 1'b0;
                  end else begin
                    col_n        = col + 4'd1;
                    state_n      = ST_DONE;
                    write_done_n = 1'b1;
                  end
                end

                default: begin
                  state_n      = ST_DONE;
                  write_done_n = 1'b1;
                end
              endcase
            end else begin
              cnt_n = cnt + 32'd1;
            end
          end
        endcase
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state        <= ST_POWERUP;
      phase        <= PH_SETUP;
      cnt          <= '0;
      init_idx     <= '0;
      col          <= '0;
      line         <= 1'b0;
      O_LCD_DB     <= '0;
      O_LCD_RS     <= 1'b0;
      O_LCD_E      <= 1'b0;
      O_INIT_DONE  <= 1'b0;
      O_WRITE_DONE <= 1'b0;
    end else begin
      state        <= state_n;
      phase        <= phase_n;
      cnt          <= cnt_n;
      init_idx     <= init_idx_n;
      col          <= col_n;
      line         <= line_n;
      O_LCD_DB     <= db_n;
      O_LCD_RS     <= rs_n;
      O_LCD_E      <= e_n;
      O_INIT_DONE  <= init_done_n;
      O_WRITE_DONE <= write_done_n;
    end
  end

endmodule

// File: tb/tb_lcd_char_controller.sv
// Scoreboard bench for lcd_char_controller: expected bus bytes and done cycles are queued
// when stimulus is driven and compared when the DUT pulses E or O_WRITE_DONE.
module tb_lcd_char_controller;

  localparam int unsigned P_PU  = 100;
  localparam int unsigned P_EN  = 4;
  localparam int unsigned P_CMD = 10;
  localparam int unsigned P_CLR = 40;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       start = 1'b0;
  logic       init_done, write_done, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_db;

  lcd_char_controller #(
    .POWERUP_CYCLES   (P_PU),
    .EN_HIGH_CYCLES   (P_EN),
    .CMD_WAIT_CYCLES  (P_CMD),
    .CLEAR_WAIT_CYCLES(P_CLR)
  ) dut (
    .I_CLK        (clk),
    .I_RST_N      (rst_n),
    .I_DATA       (data),
    .I_WRITE_START(start),
    .O_INIT_DONE  (init_done),
    .O_WRITE_DONE (write_done),
    .O_LCD_DB     (lcd_db),
    .O_LCD_RS     (lcd_rs),
    .O_LCD_RW     (lcd_rw),
    .O_LCD_E      (lcd_e)
  );

  always #5 clk = ~clk;

  // Number of rising edges since reset release; cyc == n at a negedge means edge index n-1 was last.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int compared   = 0;
  int mismatched = 0;

  logic [8:0] exp_q[$];   // {rs, db} per expected E pulse
  int         done_q[$];  // expected cyc of each O_WRITE_DONE
  int         rise_q[$];  // observed cyc of each E rise
  int         tb_col  = 0;
  logic       tb_line = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus and handshake monitor, sampling on the falling edge.
  logic       prev_e = 1'b0, prev_wd = 1'b0, prev_rs = 1'b0;
  logic [7:0] prev_db = 8'h00;
  logic [8:0] bus_exp;
  int         e_w = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_e  = 1'b0;
      prev_wd = 1'b0;
      e_w     = 0;
    end else begin
      if (lcd_e && !prev_e) begin
        rise_q.push_back(cyc);
        check("setup_before_e", 32'({prev_rs, prev_db}), 32'({lcd_rs, lcd_db}));
        check("rw_low", 32'(lcd_rw), 32'd0);
        check("e_pulse_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          bus_exp = exp_q.pop_front();
          check("bus_rs_db", 32'({lcd_rs, lcd_db}), 32'(bus_exp));
        end
      end
      if (lcd_e && prev_e)
        check("bus_hold_during_e", 32'({lcd_rs, lcd_db}), 32'({prev_rs, prev_db}));
      if (lcd_e) e_w++;
      if (!lcd_e && prev_e) begin
        check("e_width", 32'(e_w), 32'(P_EN));
        e_w = 0;
      end
      if (write_done) begin
        check("done_single_cycle", 32'(prev_wd), 32'd0);
        check("done_expected", 32'(done_q.size() > 0), 32'd1);
        if (done_q.size() > 0) check("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
      end
    end
    prev_e  = lcd_e;
    prev_wd = write_done;
    prev_rs = lcd_rs;
    prev_db = lcd_db;
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!write_done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_within_budget", 32'(write_done), 32'd1);
  endtask

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endtask

  // Setups at edges 100,115,130,145,160 and 205 (after the long clear settle); E follows one edge later.
  task automatic check_init(input string phase_tag);
    int exp_r[6] = '{102, 117, 132, 147, 162, 207};
    wait_cyc(220);
    check({phase_tag, "_init_done_low_at_219"}, 32'(init_done), 32'd0);
    @(negedge clk);
    check({phase_tag, "_init_done_high_at_220"}, 32'(init_done), 32'd1);
    for (int i = 0; i < 6; i++) begin
      int r;
      r = (rise_q.size() > 0) ? rise_q.pop_front() : -1;
      check({phase_tag, "_init_e_rise_cycle"}, 32'(r), 32'(exp_r[i]));
    end
    rise_q.delete();
  endtask

  // Drives one character at a negedge in IDLE and queues the expected bus bytes and done cycle.
  task automatic write_char(input logic [7:0] ch, input bit extra_start);
    int c;
    c     = cyc;
    start = 1'b1;
    data  = ch;
    exp_q.push_back({1'b1, ch});
    if (tb_col == 15) begin
      exp_q.push_back({1'b0, tb_line ? 8'h80 : 8'hC0});
      done_q.push_back(c + 31);
      tb_col  = 0;
      tb_line = ~tb_line;
    end else begin
      done_q.push_back(c + 16);
      tb_col++;
    end
    @(negedge clk);
    start = 1'b0;
    data  = 8'hFF;
    if (extra_start) begin
      repeat (5) @(negedge clk);
      start = 1'b1;
      data  = 8'h5A;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(100);
    @(negedge clk);
    rise_q.delete();
  endtask

  initial begin
    string hello;
    hello = "HELLO";

    #3;
    check("reset_outputs", 32'({lcd_db, lcd_rs, lcd_rw, lcd_e, init_done, write_done}), 32'd0);

    push_init();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // A start during power-up must be ignored entirely.
    wait_cyc(50);
    start = 1'b1;
    data  = 8'h48;
    @(negedge clk);
    start = 1'b0;

    check_init("first");

    write_char(8'h48, 1'b0);
    for (int i = 0; i < 5; i++) write_char(hello[i], i == 2);

    // Column is 6: ten more reach column 15 and wrap to line 1, sixteen more wrap back to line 0.
    for (int i = 0; i < 10; i++) write_char(8'h41 + 8'(i), 1'b0);
    for (int i = 0; i < 16; i++) write_char(8'h61 + 8'(i), 1'b0);

    // Reset in the middle of the E pulse of a data write.
    start = 1'b1;
    data  = 8'h52;
    exp_q.push_back({1'b1, 8'h52});
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("e_high_before_reset", 32'(lcd_e), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async_outputs", 32'({lcd_db, lcd_rs, lcd_rw, lcd_e, init_done, write_done}), 32'd0);
    check("bus_queue_at_reset", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    done_q.delete();
    rise_q.delete();
    tb_col  = 0;
    tb_line = 1'b0;
    push_init();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check_init("after_reset");

    // Cursor restarts at line 0 col 0: the 16th character wraps with 0xC0.
    for (int i = 0; i < 16; i++) write_char(8'h30 + 8'(i), 1'b0);

    repeat (5) @(negedge clk);
    check("bus_queue_drained", 32'(exp_q.size()), 32'd0);
    check("done_queue_drained", 32'(done_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, compared %0d", compared);
    $fatal(1, "timeout");
  end

endmodule
